// File: rtl/noc_params.sv
// Shared NoC parameter defaults and the elaboration-time clog2 helper.
package noc_params;

  localparam int FLIT_SIZE_DEF   = 8;
  localparam int BUFFER_SIZE_DEF = 8;
  localparam int VC_NUM_DEF      = 2;

  // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(3) = 2.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vc_input_buffer_fifo.sv
// One virtual-channel circular flit queue with registered flags and credit.
module vc_fifo
  import noc_params::*;
#(
  parameter int FLIT_SIZE   = FLIT_SIZE_DEF,
  parameter int BUFFER_SIZE = BUFFER_SIZE_DEF,
  localparam int CNT_W      = clog2(BUFFER_SIZE + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLIT_SIZE-1:0] data_i,
  input  logic                 push_i,
  input  logic                 pop_i,
  output logic [FLIT_SIZE-1:0] data_o,
  output logic                 empty_o,
  output logic                 full_o,
  output logic [CNT_W-1:0]     count_o,
  output logic                 credit_o,
  output logic                 push_drop_o,
  output logic                 pop_ign_o
);

  localparam int PTR_W = clog2(BUFFER_SIZE);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUFFER_SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUFFER_SIZE);

  logic [FLIT_SIZE-1:0] mem [BUFFER_SIZE];
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [CNT_W-1:0]     count_q;
  logic                 empty_q;
  logic                 full_q;
  logic                 credit_q;

  logic                 push_acc;
  logic                 pop_acc;
  logic [CNT_W-1:0]     count_nxt;

  // Accept/ignore decisions; a full queue still takes a push when it pops the same cycle.
  always_comb begin
    pop_acc     = pop_i & ~empty_q;
    push_acc    = push_i & (~full_q | pop_acc);
    push_drop_o = push_i & ~push_acc;
    pop_ign_o   = pop_i & empty_q;
    count_nxt   = count_q;
    case ({push_acc, pop_acc})
      2'b10:   count_nxt = count_q + CNT_W'(1);
      2'b01:   count_nxt = count_q - CNT_W'(1);
      default: count_nxt = count_q;
    endcase
  end

  // Flit storage; contents are not reset, pointers define validity.
  always_ff @(posedge clk) begin
    if (!rst && push_acc) begin
      mem[wr_ptr] <= data_i;
    end
  end

  // Pointers, occupancy, registered flags and the credit pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      credit_q <= 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop_acc) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      end
      count_q  <= count_nxt;
      empty_q  <= (count_nxt == '0);
      full_q   <= (count_nxt == CNT_FULL);
      credit_q <= pop_acc;
    end
  end

  assign data_o   = mem[rd_ptr];
  assign empty_o  = empty_q;
  assign full_o   = full_q;
  assign count_o  = count_q;
  assign credit_o = credit_q;

endmodule

// File: rtl/vc_input_buffer.sv
// Multi-VC router input buffer: write-VC decode, per-VC queues, sticky error flags.
module vc_input_buffer
  import noc_params::*;
#(
  parameter int FLIT_SIZE   = FLIT_SIZE_DEF,
  parameter int BUFFER_SIZE = BUFFER_SIZE_DEF,
  parameter int VC_NUM      = VC_NUM_DEF,
  localparam int VC_W       = (VC_NUM > 1) ? clog2(VC_NUM) : 1,
  localparam int CNT_W      = clog2(BUFFER_SIZE + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [FLIT_SIZE-1:0]        data_i,
  input  logic                        write_i,
  input  logic [VC_W-1:0]             vc_wr_i,
  input  logic [VC_NUM-1:0]           read_i,
  output logic [VC_NUM*FLIT_SIZE-1:0] data_o,
  output logic [VC_NUM-1:0]           empty_o,
  output logic [VC_NUM-1:0]           full_o,
  output logic [VC_NUM*CNT_W-1:0]     count_o,
  output logic [VC_NUM-1:0]           credit_o,
  output logic                        overflow_o,
  output logic                        underflow_o
);

  localparam logic [VC_W:0] VC_LIM = (VC_W + 1)'(VC_NUM);

  logic              vc_in_range;
  logic [VC_NUM-1:0] push;
  logic [VC_NUM-1:0] push_drop;
  logic [VC_NUM-1:0] pop_ign;
  logic              overflow_q;
  logic              underflow_q;

  assign vc_in_range = ({1'b0, vc_wr_i} < VC_LIM);

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    assign push[v] = write_i & vc_in_range & (vc_wr_i == VC_W'(v));

    vc_fifo #(
      .FLIT_SIZE   (FLIT_SIZE),
      .BUFFER_SIZE (BUFFER_SIZE)
    ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .data_i      (data_i),
      .push_i      (push[v]),
      .pop_i       (read_i[v]),
      .data_o      (data_o[v*FLIT_SIZE +: FLIT_SIZE]),
      .empty_o     (empty_o[v]),
      .full_o      (full_o[v]),
      .count_o     (count_o[v*CNT_W +: CNT_W]),
      .credit_o    (credit_o[v]),
      .push_drop_o (push_drop[v]),
      .pop_ign_o   (pop_ign[v])
    );
  end

  // Sticky error flags: any dropped push or ignored pop, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if ((|push_drop) || (write_i && !vc_in_range)) begin
        overflow_q <= 1'b1;
      end
      if (|pop_ign) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

endmodule

// File: tb/tb_vc_input_buffer.sv
// Self-checking bench for vc_input_buffer (2 VCs, depth 3) against a queue model.
module tb_vc_input_buffer;

  localparam int FW = 8;
  localparam int BS = 3;
  localparam int VN = 2;
  localparam int CW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [FW-1:0]     data_i;
  logic              write_i;
  logic [0:0]        vc_wr_i;
  logic [VN-1:0]     read_i;
  logic [VN*FW-1:0]  data_o;
  logic [VN-1:0]     empty_o;
  logic [VN-1:0]     full_o;
  logic [VN*CW-1:0]  count_o;
  logic [VN-1:0]     credit_o;
  logic              overflow_o;
  logic              underflow_o;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: one FIFO queue per VC plus expected flags.
  logic [FW-1:0] q [VN][$];
  logic [VN-1:0] exp_credit;
  logic          exp_ov;
  logic          exp_un;

  vc_input_buffer #(
    .FLIT_SIZE   (FW),
    .BUFFER_SIZE (BS),
    .VC_NUM      (VN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_i      (data_i),
    .write_i     (write_i),
    .vc_wr_i     (vc_wr_i),
    .read_i      (read_i),
    .data_o      (data_o),
    .empty_o     (empty_o),
    .full_o      (full_o),
    .count_o     (count_o),
    .credit_o    (credit_o),
    .overflow_o  (overflow_o),
    .underflow_o (underflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int v = 0; v < VN; v++) begin
      chk($sformatf("empty%0d", v), 32'(empty_o[v]), 32'(q[v].size() == 0));
      chk($sformatf("full%0d", v), 32'(full_o[v]), 32'(q[v].size() == BS));
      chk($sformatf("count%0d", v), 32'(count_o[v*CW +: CW]), 32'(q[v].size()));
      chk($sformatf("credit%0d", v), 32'(credit_o[v]), 32'(exp_credit[v]));
      if (q[v].size() > 0) begin
        chk($sformatf("head%0d", v), 32'(data_o[v*FW +: FW]), 32'(q[v][0]));
      end
    end
    chk("overflow", 32'(overflow_o), 32'(exp_ov));
    chk("underflow", 32'(underflow_o), 32'(exp_un));
  endtask

  task automatic step(input logic w, input logic vc, input logic [FW-1:0] d,
                      input logic [VN-1:0] rd);
    logic [VN-1:0] pok;
    logic          wok;
    write_i = w;
    vc_wr_i = vc;
    data_i  = d;
    read_i  = rd;
    for (int v = 0; v < VN; v++) begin
      pok[v] = rd[v] && (q[v].size() > 0);
      if (pok[v]) begin
        chk($sformatf("pop_data%0d", v), 32'(data_o[v*FW +: FW]), 32'(q[v][0]));
      end
      if (rd[v] && !pok[v]) exp_un = 1'b1;
    end
    wok = w && ((q[vc].size() < BS) || pok[vc]);
    if (w && !wok) exp_ov = 1'b1;
    @(posedge clk);
    #1;
    for (int v = 0; v < VN; v++) begin
      if (pok[v]) void'(q[v].pop_front());
    end
    if (wok) q[vc].push_back(d);
    exp_credit = pok;
    write_i = 1'b0;
    read_i  = '0;
    check_all();
  endtask

  task automatic rst_step(input logic w, input logic vc, input logic [FW-1:0] d,
                          input logic [VN-1:0] rd);
    write_i = w;
    vc_wr_i = vc;
    data_i  = d;
    read_i  = rd;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    write_i = 1'b0;
    read_i  = '0;
    for (int v = 0; v < VN; v++) q[v].delete();
    exp_credit = '0;
    exp_ov     = 1'b0;
    exp_un     = 1'b0;
    check_all();
  endtask

  initial begin
    rst = 1'b1; write_i = 1'b0; vc_wr_i = '0; data_i = '0; read_i = '0;
    exp_credit = '0; exp_ov = 1'b0; exp_un = 1'b0;
    @(posedge clk);
    #1;
    rst_step(1'b0, 1'b0, 8'h00, 2'b00);
    step(1'b0, 1'b0, 8'h00, 2'b00);

    // Fill VC1 to full, then drain it back-to-back.
    step(1'b1, 1'b1, 8'h11, 2'b00);
    step(1'b1, 1'b1, 8'h22, 2'b00);
    step(1'b1, 1'b1, 8'h33, 2'b00);
    chk("vc1_full", 32'(full_o[1]), 32'd1);
    step(1'b0, 1'b0, 8'h00, 2'b10);
    step(1'b0, 1'b0, 8'h00, 2'b10);
    step(1'b0, 1'b0, 8'h00, 2'b10);
    chk("vc1_drained", 32'(empty_o[1]), 32'd1);

    // VC0 full with head A0: push+pop, then dropped push, then pop on empty VC1.
    step(1'b1, 1'b0, 8'hA0, 2'b00);
    step(1'b1, 1'b0, 8'hA1, 2'b00);
    step(1'b1, 1'b0, 8'hA2, 2'b00);
    step(1'b1, 1'b0, 8'hB0, 2'b01);
    chk("full_pp_ov", 32'(overflow_o), 32'd0);
    chk("full_pp_cnt", 32'(count_o[0 +: CW]), 32'd3);
    step(1'b1, 1'b0, 8'hB1, 2'b00);
    chk("ov_set", 32'(overflow_o), 32'd1);
    step(1'b0, 1'b0, 8'h00, 2'b00);
    step(1'b0, 1'b0, 8'h00, 2'b10);
    chk("un_set", 32'(underflow_o), 32'd1);
    step(1'b0, 1'b0, 8'h00, 2'b01);
    step(1'b0, 1'b0, 8'h00, 2'b01);
    step(1'b0, 1'b0, 8'h00, 2'b01);

    // Empty VC0: simultaneous push and pop, no fall-through.
    rst_step(1'b0, 1'b0, 8'h00, 2'b00);
    step(1'b1, 1'b0, 8'h5C, 2'b01);
    chk("empty_pp_head", 32'(data_o[0 +: FW]), 32'h5C);
    chk("empty_pp_credit", 32'(credit_o[0]), 32'd0);

    // Random mixed traffic, then reset mid-stream with traffic in flight.
    for (int i = 0; i < 20; i++) begin
      step(1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom),
           2'($urandom_range(3)));
    end
    rst_step(1'b1, 1'($urandom_range(1)), 8'($urandom), 2'b11);
    step(1'b0, 1'b0, 8'h00, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
